data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the CPU data-memory interface: serves mem_ren/mem_wen requests
//  from the datapath out of a word-organised on-chip RAM with programmable wait states.
//  Drives mem_ready back to the CPU wrapper, which gates cpu_en while a request is
//  pending, so the single-cycle datapath stalls without any changes to its own logic.
// PARAMETERS
//  ADDR_WIDTH  10  word-address bits; depth = 2**ADDR_WIDTH words of 32 bits
//  LATENCY     2   wait cycles between request capture and completion (0..15)
// PORTS
//  clk        in   1   main clock; all state updates on posedge
//  cpu_rst_n  in   1   asynchronous, active-low reset
//  mem_ren    in   1   read request (level), held by CPU until mem_ready=1
//  mem_wen    in   1   write request (level), held by CPU until mem_ready=1
//  mem_addr   in   32  byte address; word index = mem_addr[ADDR_WIDTH+1:2]
//  mem_wdata  in   32  write data (the CPU's mem_dout)
//  mem_rdata  out  32  read data (the CPU's mem_din), valid while state=DONE
//  mem_ready  out  1   1 = no request outstanding or the current one completes this cycle
//  mem_err    out  1   out-of-range access flag (MEM_BOUNDS_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (async, cpu_rst_n=0): state=IDLE, wait counter=0, mem_rdata=0, mem_err=0.
//    RAM contents are not cleared. A pending write is discarded.
//  - req = mem_ren | mem_wen. Write wins: with both high, the access is a write.
//  - FSM states:
//    IDLE: if req, capture addr, wdata and type; go WAIT (or DONE if LATENCY=0),
//          counter=0. Otherwise stay.
//    WAIT: counter++; when counter==LATENCY-1, go DONE. The RAM access is
//          performed on this final edge: write commits, or mem_rdata <= RAM[idx].
//    DONE: one cycle; go IDLE unconditionally.
//  - mem_ready = (state==DONE) | (state==IDLE & ~req). Combinational, so the CPU
//    stalls in the same cycle it raises a request.
//  - Stall per access = LATENCY+1 cycles; the CPU advances on the edge ending DONE.
//  - Captured values are fixed. Changes to mem_addr/mem_wdata or deassertion of req
//    after capture are ignored, and the transaction completes regardless.
//  - Back-to-back requests: DONE->IDLE costs one cycle. A request held in IDLE is
//    recaptured there, with no bubble beyond that cycle.
//  - For a write, mem_rdata keeps its previous value. Outside DONE, mem_rdata holds
//    its last value.
//  - mem_addr[1:0] is ignored (word access only). Bits above ADDR_WIDTH+1 are
//    handled per CONFIGURATION.
//  - Counter width is 4 bits; LATENCY>15 is illegal (elaboration check via $error).
// CONFIGURATION
//  MEM_BOUNDS_EN defined:
//    - Any nonzero mem_addr[31:ADDR_WIDTH+2] at capture is out of range.
//    - Out-of-range writes are suppressed; out-of-range reads return 32'hDEAD_BEEF.
//    - mem_err=1 during that access's DONE cycle only. Timing is unchanged.
//  MEM_BOUNDS_EN undefined:
//    - Upper address bits are ignored, so the address wraps modulo the depth.
//    - mem_err is constant 0.
// TESTING
//  1 Reset: cpu_rst_n=0 mid-WAIT of a write of 0x1234_5678 to 0x10 -> IDLE at once,
//    mem_ready=1, and a later read of 0x10 returns the old value.
//  2 LATENCY=2: write 0xA5A5_0001 to 0x40, then read 0x40 -> each has mem_ready=0 for
//    3 cycles; the read returns 0xA5A5_0001 in DONE.
//  3 LATENCY=0: read 0x0 -> mem_ready=0 for exactly 1 cycle, then DONE with data.
//  4 mem_ren=mem_wen=1, addr 0x8, data 0xCAFE_F00D -> the write commits, mem_rdata is
//    unchanged, and a following read returns 0xCAFE_F00D.
//  5 Change mem_addr to 0x20 in WAIT of a read from 0x4 -> data from 0x4 is returned.
//  6 ADDR_WIDTH=10, write addr 0x1000: with MEM_BOUNDS_EN -> mem_err=1 in DONE, a read
//    of 0x0 is unchanged, and a read of 0x1000 returns 0xDEAD_BEEF. Without it -> the
//    write aliases word 0.

Source files
------------

// File: rtl/data_mem_if.sv
// Data-memory bus between the CPU wrapper (master) and the memory responder (slave).
//  mem_ren   read request, held until mem_ready
//  mem_wen   write request, held until mem_ready
//  mem_addr  byte address
//  mem_wdata write data
//  mem_rdata read data, valid in the completing cycle
//  mem_ready no request outstanding, or the current one completes this cycle
//  mem_err   out-of-range access flag
interface data_mem_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, mem_err
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, mem_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory interface. Serves read/write requests from a
// word-organised on-chip RAM after LATENCY programmable wait cycles; mem_ready stalls
// the CPU combinationally from the cycle a request is raised until it completes.
// Ports:
//  clk        main clock
//  cpu_rst_n  asynchronous active-low reset (RAM contents are kept)
//  mem        data_mem_if.slave bus (requests in, rdata/ready/err out)
// Optional feature: define MEM_BOUNDS_EN to flag and suppress accesses with nonzero
// address bits above the RAM range (reads return 32'hDEAD_BEEF, mem_err=1 in DONE).
// Without it the upper address bits are ignored and mem_err is tied 0.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input logic       clk,
    input logic       cpu_rst_n,
    data_mem_if.slave mem
);

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LAST_CNT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (LATENCY < 0 || LATENCY > 15) begin : g_latency_check
        $error("data_mem_responder: LATENCY must be in 0..15");
    end

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] ram [DEPTH];

    logic                  req;
    logic                  access;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic                  acc_wr;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  oor;

    assign req = mem.mem_ren | mem.mem_wen;

    // With zero latency the RAM access happens on the capture edge itself, so it
    // must use the live bus values rather than the (not yet loaded) capture registers.
    always_comb begin
        access    = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wr    = wr_q;
        if (LATENCY == 0) begin
            access    = (state_q == ST_IDLE) && req;
            acc_addr  = mem.mem_addr;
            acc_wdata = mem.mem_wdata;
            acc_wr    = mem.mem_wen;
        end else begin
            access = (state_q == ST_WAIT) && (cnt_q == LAST_CNT);
        end
    end

    assign acc_idx = acc_addr[ADDR_WIDTH+1:2];

`ifdef MEM_BOUNDS_EN
    assign oor = |acc_addr[31:ADDR_WIDTH+2];
    logic unused_addr_bits;
    assign unused_addr_bits = ^acc_addr[1:0];
`else
    // Upper bits are dropped so the address wraps modulo the RAM depth.
    assign oor = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[31:ADDR_WIDTH+2]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = mem.mem_addr;
                    wdata_d = mem.mem_wdata;
                    wr_d    = mem.mem_wen;   // write wins when both are raised
                    cnt_d   = 4'd0;
                    state_d = (LATENCY == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            if (access && !acc_wr) begin
                rdata_q <= oor ? 32'hDEAD_BEEF : ram[acc_idx];
            end
            // err is loaded on the edge entering DONE and cleared on the edge leaving it.
            if (access) begin
                err_q <= oor;
            end else if (state_q == ST_DONE) begin
                err_q <= 1'b0;
            end
        end
    end

    // RAM is not reset; gating with cpu_rst_n drops a zero-latency write under reset.
    always_ff @(posedge clk) begin
        if (cpu_rst_n && access && acc_wr && !oor) begin
            ram[acc_idx] <= acc_wdata;
        end
    end

    assign mem.mem_rdata = rdata_q;
    assign mem.mem_err   = err_q;
    assign mem.mem_ready = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);

endmodule
